// File: rtl/irq_injector.sv
// Address-triggered interrupt injector: a table of one-shot triggers that pulse an irq line.
// Optional build macro IRQ_INJECTOR_REARM_EN keeps entries armed and re-fires them after addr moves away.
module irq_injector #(
   parameter int NUM_TRIG = 16,
   parameter int NUM_CH   = 6,
   parameter int HOLD_W   = 8,
   localparam int IDX_W   = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       addr,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [31:0]       cfg_addr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [HOLD_W-1:0] cfg_hold,
   output logic [NUM_CH-1:0] irq,
   output logic              busy,
   output logic [7:0]        fire_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_ASSERT = 1'b1} state_t;

   state_t              r_state;
   logic [NUM_TRIG-1:0] r_armed;
   logic [31:0]         r_taddr [NUM_TRIG];
   logic [CH_W-1:0]     r_tch   [NUM_TRIG];
   logic [HOLD_W-1:0]   r_thold [NUM_TRIG];
   logic [HOLD_W-1:0]   r_cnt;
   logic [NUM_CH-1:0]   r_irq;
   logic                r_busy;
   logic [7:0]          r_fire_cnt;
`ifdef IRQ_INJECTOR_REARM_EN
   logic [NUM_TRIG-1:0] r_away;
`endif

   logic [NUM_TRIG-1:0] w_match;
   logic                w_hit;
   logic [IDX_W-1:0]    w_hit_idx;
   logic [NUM_CH-1:0]   w_hit_oh;

   // Per-entry address compare against the live PC
   always_comb begin
      w_match = '0;
      for (int i = 0; i < NUM_TRIG; i++) begin
`ifdef IRQ_INJECTOR_REARM_EN
         w_match[i] = r_armed[i] & r_away[i] & (r_taddr[i] == addr);
`else
         w_match[i] = r_armed[i] & (r_taddr[i] == addr);
`endif
      end
   end

   // Lowest-index match wins; scanning downward lets the lowest index overwrite
   always_comb begin
      w_hit     = |w_match;
      w_hit_idx = '0;
      for (int i = NUM_TRIG - 1; i >= 0; i--) begin
         w_hit_idx = w_match[i] ? IDX_W'(i) : w_hit_idx;
      end
      w_hit_oh = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         w_hit_oh[j] = (r_tch[w_hit_idx] == CH_W'(j));
      end
   end

   // Table payload; contents survive reset, only armed bits are cleared
   always_ff @(posedge clk) begin
      if (cfg_we) begin
         r_taddr[cfg_idx] <= cfg_addr;
         r_tch[cfg_idx]   <= cfg_ch;
         r_thold[cfg_idx] <= cfg_hold;
      end
   end

   // Pulse FSM, armed/away bookkeeping and fire counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_armed    <= '0;
         r_cnt      <= '0;
         r_irq      <= '0;
         r_busy     <= 1'b0;
         r_fire_cnt <= 8'd0;
`ifdef IRQ_INJECTOR_REARM_EN
         r_away     <= '0;
`endif
      end else begin
`ifdef IRQ_INJECTOR_REARM_EN
         for (int i = 0; i < NUM_TRIG; i++) begin
            r_away[i] <= r_away[i] | (addr != r_taddr[i]);
         end
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_state <= ST_ASSERT;
                  r_cnt   <= r_thold[w_hit_idx];
                  r_irq   <= w_hit_oh;
                  r_busy  <= 1'b1;
                  if (r_fire_cnt != 8'hFF) begin
                     r_fire_cnt <= r_fire_cnt + 8'd1;
                  end
`ifdef IRQ_INJECTOR_REARM_EN
                  r_away[w_hit_idx]  <= 1'b0;
`else
                  r_armed[w_hit_idx] <= 1'b0;
`endif
               end
            end
            ST_ASSERT: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
                  r_irq   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - HOLD_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_irq   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
         // A same-edge write lands after the fire-clear so the new entry ends up armed
         if (cfg_we) begin
            r_armed[cfg_idx] <= 1'b1;
`ifdef IRQ_INJECTOR_REARM_EN
            r_away[cfg_idx]  <= 1'b1;
`endif
         end
      end
   end

   assign irq      = r_irq;
   assign busy     = r_busy;
   assign fire_cnt = r_fire_cnt;

endmodule
